// File: rtl/minion_sprite_render.sv
// Per-pixel renderer for a single 32x51 minion sprite: frame-latched position,
// sprite ROM addressing, palette lookup with transparency and a hit-flash effect.
module minion_sprite_render #(
    parameter int SPR_W        = 32,
    parameter int SPR_H        = 51,
    parameter int ADDR_W       = 19,
    parameter int FLASH_FRAMES = 24
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              visible,
    input  logic              hit,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] read_address,
    input  logic [2:0]        color_idx,
    output logic              sprite_on,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hit_active
);

    localparam logic [5:0]  FLASH_LOAD = 6'(FLASH_FRAMES);
    localparam logic [10:0] BOX_W      = 11'(SPR_W);
    localparam logic [10:0] BOX_H      = 11'(SPR_H);
    localparam logic [23:0] WHITE      = 24'hFFFFFF;

    logic [9:0]        lat_x;
    logic [9:0]        lat_y;
    logic              lat_vis;
    logic [5:0]        flash_cnt;
    logic              in_box_d1;

    logic [10:0]       x_ext;
    logic [10:0]       y_ext;
    logic [10:0]       lx_ext;
    logic [10:0]       ly_ext;
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic              in_box;
    logic [ADDR_W-1:0] addr_calc;
    logic              opaque;
    logic              flashing;
    logic [23:0]       rgb_next;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        logic [23:0] rgb;
        rgb = 24'h000000;
        case (idx)
            3'd1:    rgb = 24'h00FFFF;
            3'd2:    rgb = 24'h008080;
            3'd3:    rgb = 24'h9CE5F4;
            3'd4:    rgb = 24'h406070;
            3'd5:    rgb = 24'h000000;
            3'd6:    rgb = 24'hFFFFFF;
            3'd7:    rgb = 24'h808080;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    // Box test is done in 11 bits so a sprite near the right/bottom edge
    // never wraps back onto column/row 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        x_ext     = {1'b0, DrawX};
        y_ext     = {1'b0, DrawY};
        lx_ext    = {1'b0, lat_x};
        ly_ext    = {1'b0, lat_y};
        dx        = x_ext - lx_ext;
        dy        = y_ext - ly_ext;
        in_box    = lat_vis
                    && (x_ext >= lx_ext) && (x_ext < lx_ext + BOX_W)
                    && (y_ext >= ly_ext) && (y_ext < ly_ext + BOX_H);
        addr_calc = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
    end

    assign hit_active = (flash_cnt != 6'd0);
    assign flashing   = hit_active && flash_cnt[2];
    assign opaque     = in_box_d1 && (color_idx != 3'd0);
    assign rgb_next   = flashing ? WHITE : palette(color_idx);

    // Position only changes at frame boundaries so a frame never tears.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!Reset_n) begin
            lat_x   <= '0;
            lat_y   <= '0;
            lat_vis <= 1'b0;
        end else if (frame_start) begin
            lat_x   <= pos_x;
            lat_y   <= pos_y;
            lat_vis <= visible;
        end
    end

    // A hit restarts the effect even if it lands on a frame_start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_cnt <= '0;
        end else if (hit) begin
            flash_cnt <= FLASH_LOAD;
        end else if (frame_start && hit_active) begin
            flash_cnt <= flash_cnt - 6'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            in_box_d1    <= 1'b0;
            sprite_on    <= 1'b0;
            red          <= '0;
            green        <= '0;
            blue         <= '0;
        end else begin
            read_address <= in_box ? addr_calc : '0;
            in_box_d1    <= in_box;
            sprite_on    <= opaque;
            {red, green, blue} <= opaque ? rgb_next : 24'h000000;
        end
    end

endmodule

// File: tb/tb_minion_sprite_render.sv
// Scoreboard bench for minion_sprite_render: pixels push expected address and
// colour into queues; a monitor pops them 1 and 2 clocks later and compares.
module tb_minion_sprite_render;

    typedef struct {
        logic        on;
        logic [23:0] rgb;
    } pix_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        visible = 1'b0;
    logic        hit = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [18:0] read_address;
    logic [2:0]  color_idx;
    logic        sprite_on;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hit_active;
    logic [23:0] rgb;

    int n_checks = 0;
    int n_pass   = 0;

    logic        probe = 1'b0;
    logic        probe_d1;
    logic        probe_d2;
    logic [18:0] addr_q[$];
    pix_t        pix_q[$];

    minion_sprite_render dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .visible      (visible),
        .hit          (hit),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .read_address (read_address),
        .color_idx    (color_idx),
        .sprite_on    (sprite_on),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hit_active   (hit_active)
    );

    // ROM model: colour index is the low three address bits.
    assign color_idx = read_address[2:0];
    assign rgb       = {red, green, blue};

    always #5 Clk = ~Clk;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            probe_d1 <= 1'b0;
            probe_d2 <= 1'b0;
        end else begin
            probe_d1 <= probe;
            probe_d2 <= probe_d1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge Clk) begin
        if (probe_d1) begin
            if (addr_q.size() == 0) check("addr_q_underflow", 32'd1, 32'd0);
            else check("read_address", 32'(read_address), 32'(addr_q.pop_front()));
        end
        if (probe_d2) begin
            if (pix_q.size() == 0) begin
                check("pix_q_underflow", 32'd1, 32'd0);
            end else begin
                pix_t e;
                e = pix_q.pop_front();
                check("sprite_on", 32'(sprite_on), 32'(e.on));
                check("rgb", 32'(rgb), 32'(e.rgb));
            end
        end
    end

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [18:0] ea,
                       input logic eon, input logic [23:0] ergb);
        pix_t e;
        @(negedge Clk);
        DrawX = x;
        DrawY = y;
        probe = 1'b1;
        e.on  = eon;
        e.rgb = ergb;
        addr_q.push_back(ea);
        pix_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            probe = 1'b0;
        end
    endtask

    task automatic pulse(input logic fs, input logic h);
        @(negedge Clk);
        probe       = 1'b0;
        frame_start = fs;
        hit         = h;
        @(negedge Clk);
        frame_start = 1'b0;
        hit         = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        idle(2);
        check("rst_addr", 32'(read_address), 32'd0);
        check("rst_on", 32'(sprite_on), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_hit_active", 32'(hit_active), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Requested position is ignored until frame_start
        pos_x = 10'd100; pos_y = 10'd50; visible = 1'b1;
        pix(10'd100, 10'd50, 19'd0, 1'b0, 24'h0);
        pix(10'd101, 10'd50, 19'd0, 1'b0, 24'h0);
        idle(3);

        // Addressing and palette
        pulse(1'b1, 1'b0);
        pix(10'd100, 10'd50,  19'd0,    1'b0, 24'h000000);
        pix(10'd101, 10'd50,  19'd1,    1'b1, 24'h00FFFF);
        pix(10'd131, 10'd100, 19'd1631, 1'b1, 24'h808080);
        pix(10'd132, 10'd100, 19'd0,    1'b0, 24'h000000);
        pix(10'd99,  10'd50,  19'd0,    1'b0, 24'h000000);
        pix(10'd102, 10'd50,  19'd2,    1'b1, 24'h008080);
        pix(10'd103, 10'd50,  19'd3,    1'b1, 24'h9CE5F4);
        pix(10'd104, 10'd50,  19'd4,    1'b1, 24'h406070);
        pix(10'd105, 10'd50,  19'd5,    1'b1, 24'h000000);
        pix(10'd106, 10'd50,  19'd6,    1'b1, 24'hFFFFFF);
        pix(10'd100, 10'd51,  19'd32,   1'b0, 24'h000000);
        pix(10'd101, 10'd100, 19'd1601, 1'b1, 24'h00FFFF);
        pix(10'd100, 10'd49,  19'd0,    1'b0, 24'h000000);
        pix(10'd100, 10'd101, 19'd0,    1'b0, 24'h000000);
        idle(3);

        // Shadow latch
        pos_x = 10'd200;
        pix(10'd101, 10'd50, 19'd1, 1'b1, 24'h00FFFF);
        pix(10'd201, 10'd50, 19'd0, 1'b0, 24'h000000);
        idle(3);
        pulse(1'b1, 1'b0);
        pix(10'd200, 10'd50, 19'd0, 1'b0, 24'h000000);
        pix(10'd201, 10'd50, 19'd1, 1'b1, 24'h00FFFF);
        pix(10'd101, 10'd50, 19'd0, 1'b0, 24'h000000);
        idle(3);

        // Flash: count 24 is not a flash phase, 20 is
        pulse(1'b0, 1'b1);
        check("hit_active_after_hit", 32'(hit_active), 32'd1);
        pix(10'd201, 10'd50, 19'd1, 1'b1, 24'h00FFFF);
        idle(3);
        for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
        pix(10'd201, 10'd50, 19'd1, 1'b1, 24'hFFFFFF);
        pix(10'd200, 10'd50, 19'd0, 1'b0, 24'h000000);
        pix(10'd202, 10'd50, 19'd2, 1'b1, 24'hFFFFFF);
        idle(3);
        pulse(1'b1, 1'b1);
        pix(10'd201, 10'd50, 19'd1, 1'b1, 24'h00FFFF);
        idle(3);
        for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0);
        check("hit_active_cnt1", 32'(hit_active), 32'd1);
        pulse(1'b1, 1'b0);
        check("hit_active_expired", 32'(hit_active), 32'd0);
        pulse(1'b1, 1'b0);
        check("hit_active_saturate", 32'(hit_active), 32'd0);

        // Right/bottom edge
        pos_x = 10'd620; pos_y = 10'd0;
        pulse(1'b1, 1'b0);
        pix(10'd639, 10'd0,  19'd19,   1'b1, 24'h9CE5F4);
        pix(10'd619, 10'd0,  19'd0,    1'b0, 24'h000000);
        pix(10'd620, 10'd50, 19'd1600, 1'b0, 24'h000000);
        pix(10'd621, 10'd50, 19'd1601, 1'b1, 24'h00FFFF);
        pix(10'd620, 10'd51, 19'd0,    1'b0, 24'h000000);
        idle(3);
        check("queues_drained", 32'(addr_q.size() + pix_q.size()), 32'd0);

        // Asynchronous reset mid-frame with the sprite on
        pulse(1'b0, 1'b1);
        @(negedge Clk);
        DrawX = 10'd621; DrawY = 10'd50;
        idle(3);
        check("pre_rst_on", 32'(sprite_on), 32'd1);
        check("pre_rst_hit_active", 32'(hit_active), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_addr", 32'(read_address), 32'd0);
        check("async_rst_on", 32'(sprite_on), 32'd0);
        check("async_rst_rgb", 32'(rgb), 32'd0);
        check("async_rst_hit_active", 32'(hit_active), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(4);
        check("post_rst_on", 32'(sprite_on), 32'd0);
        check("post_rst_addr", 32'(read_address), 32'd0);
        pulse(1'b1, 1'b0);
        idle(3);
        check("refresh_on", 32'(sprite_on), 32'd1);
        check("refresh_addr", 32'(read_address), 32'd1601);
        check("refresh_rgb", 32'(rgb), 32'h00FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
